invader_formation: RTL and testbench

Parametrised formation controller for the enemy grid: ROWS x COLS invaders marching as one block, with a per-cell alive mask. March edges come from the outermost living columns, march rate speeds up as invaders die, and the block reports landing and wave-cleared. It sits between the frame timing and the per-enemy sprite renderers, and accepts hit reports from the missile collision logic.

---
 rtl/invader_formation.sv | 163 ++++++++++++++++
 tb/tb_invader_formation.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/invader_formation.sv
// Enemy formation controller: marches a ROWS x COLS block across the screen,
// tracks which cells are alive, and reports landing and wave-cleared.
module invader_formation #(
  parameter int ROWS        = 5,
  parameter int COLS        = 11,
  parameter int CELL_W      = 32,
  parameter int CELL_H      = 24,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 8,
  parameter int START_X     = 64,
  parameter int START_Y     = 32,
  parameter int SCREEN_W    = 640,
  parameter int LAND_Y      = 400,
  parameter int SPEED_SHIFT = 2
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_tick,
  input  logic                           Start,
  input  logic                           hit_valid,
  input  logic [$clog2(ROWS)-1:0]        hit_row,
  input  logic [$clog2(COLS)-1:0]        hit_col,
  output logic [9:0]                     origin_x,
  output logic [9:0]                     origin_y,
  output logic [ROWS*COLS-1:0]           alive_mask,
  output logic [$clog2(ROWS*COLS+1)-1:0] alive_count,
  output logic                           dir_right,
  output logic                           hit_ack,
  output logic                           hit_killed,
  output logic                           landed,
  output logic                           cleared
);
  localparam int N   = ROWS * COLS;
  localparam int CNW = $clog2(N + 1);
  localparam int IW  = $clog2(N);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);

  typedef enum logic [2:0] {IDLE, MARCH_R, MARCH_L, DROP, LANDED, CLEARED} state_t;
  state_t state, state_nxt;

  logic [9:0]     ox_nxt, oy_nxt;
  logic [N-1:0]   mask_nxt;
  logic [CNW-1:0] cnt_nxt, div_cnt, div_nxt, period;
  logic           dir_nxt, do_move, hit_in_range, hit_kill;
  logic [IW-1:0]  hit_idx;
  logic [COLS-1:0] col_alive;
  logic [ROWS-1:0] row_alive;
  logic [CLW-1:0] lc, rc;
  logic [RW-1:0]  rb;
  logic [10:0]    right_edge, left_edge, drop_bottom;
  logic           at_right, at_left;

  genvar r;
  for (r = 0; r < ROWS; r++) begin : g_row
    assign row_alive[r] = |alive_mask[r*COLS +: COLS];
  end

  // Occupied extents of the living block; an empty mask defaults to 0.
  always_comb begin
    col_alive = '0;
    lc = '0;
    rc = '0;
    rb = '0;
    for (int c = 0; c < COLS; c++)
      for (int i = 0; i < ROWS; i++)
        if (alive_mask[i*COLS + c]) col_alive[c] = 1'b1;
    for (int c = COLS-1; c >= 0; c--) if (col_alive[c]) lc = CLW'(c);
    for (int c = 0; c < COLS; c++)    if (col_alive[c]) rc = CLW'(c);
    for (int i = 0; i < ROWS; i++)    if (row_alive[i]) rb = RW'(i);
  end

  assign right_edge  = {1'b0, origin_x} + (11'(rc) + 11'd1) * 11'(CELL_W) - 11'd1;
  assign left_edge   = {1'b0, origin_x} + 11'(lc) * 11'(CELL_W);
  assign drop_bottom = {1'b0, origin_y} + 11'(STEP_Y) + (11'(rb) + 11'd1) * 11'(CELL_H);
  assign at_right    = (right_edge + 11'(STEP_X)) > 11'(SCREEN_W - 1);
  // Also turn when the origin itself would underflow (left columns dead).
  assign at_left     = (left_edge < 11'(STEP_X)) || (origin_x < 10'(STEP_X));

  assign period       = alive_count >> SPEED_SHIFT;
  assign hit_in_range = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
  assign hit_idx      = hit_in_range ? IW'(int'(hit_row) * COLS + int'(hit_col)) : '0;
  assign hit_kill     = hit_valid && hit_in_range && alive_mask[hit_idx];

  always_comb begin
    state_nxt = state;
    ox_nxt    = origin_x;
    oy_nxt    = origin_y;
    dir_nxt   = dir_right;
    div_nxt   = div_cnt;
    mask_nxt  = alive_mask;
    cnt_nxt   = alive_count;
    do_move   = 1'b0;
    if (hit_kill) begin
      mask_nxt[hit_idx] = 1'b0;
      cnt_nxt = alive_count - CNW'(1);
    end
    if (frame_tick && (state == MARCH_R || state == MARCH_L)) begin
      if (div_cnt >= period) begin
        div_nxt = '0;
        do_move = 1'b1;
      end else begin
        div_nxt = div_cnt + CNW'(1);
      end
    end
    case (state)
      IDLE:    if (Start) state_nxt = MARCH_R;
      MARCH_R: if (do_move) begin
                 if (at_right) state_nxt = DROP;
                 else          ox_nxt = origin_x + 10'(STEP_X);
               end
      MARCH_L: if (do_move) begin
                 if (at_left) state_nxt = DROP;
                 else         ox_nxt = origin_x - 10'(STEP_X);
               end
      DROP: begin
        oy_nxt  = origin_y + 10'(STEP_Y);
        dir_nxt = !dir_right;
        if (drop_bottom >= 11'(LAND_Y)) state_nxt = LANDED;
        else                            state_nxt = dir_right ? MARCH_L : MARCH_R;
      end
      LANDED, CLEARED: if (Start) begin
        ox_nxt    = 10'(START_X);
        oy_nxt    = 10'(START_Y);
        mask_nxt  = '1;
        cnt_nxt   = CNW'(N);
        dir_nxt   = 1'b1;
        div_nxt   = '0;
        state_nxt = MARCH_R;
      end
      default: state_nxt = IDLE;
    endcase
    // Wave clear overrides whatever the march would have done.
    if (cnt_nxt == '0) state_nxt = CLEARED;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      origin_x    <= 10'(START_X);
      origin_y    <= 10'(START_Y);
      alive_mask  <= '1;
      alive_count <= CNW'(N);
      dir_right   <= 1'b1;
      div_cnt     <= '0;
      hit_ack     <= 1'b0;
      hit_killed  <= 1'b0;
    end else begin
      state       <= state_nxt;
      origin_x    <= ox_nxt;
      origin_y    <= oy_nxt;
      alive_mask  <= mask_nxt;
      alive_count <= cnt_nxt;
      dir_right   <= dir_nxt;
      div_cnt     <= div_nxt;
      hit_ack     <= hit_valid;
      hit_killed  <= hit_kill;
    end
  end

  assign landed  = (state == LANDED);
  assign cleared = (state == CLEARED);
endmodule

// File: tb/tb_invader_formation.sv
// Bench for invader_formation: hit table, directed march/drop/land/clear
// sequences, and random traffic against an array-based formation model.
module tb_invader_formation;
  localparam int ROWS = 5, COLS = 11, N = 55;
  localparam int CELL_W = 32, CELL_H = 24, STEP_X = 2, STEP_Y = 8;
  localparam int SCREEN_W = 640, LAND_Y = 400;
  localparam int S_IDLE = 0, S_MR = 1, S_ML = 2, S_DROP = 3, S_LAND = 4, S_CLR = 5;
  localparam logic [85:0] RST_VEC = {10'd64, 10'd32, {55{1'b1}}, 6'd55, 1'b1, 4'b0};

  logic Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, Start = 1'b0, hit_valid = 1'b0;
  logic [2:0] hit_row = '0;
  logic [3:0] hit_col = '0;
  logic [9:0] origin_x, origin_y;
  logic [N-1:0] alive_mask;
  logic [5:0] alive_count;
  logic dir_right, hit_ack, hit_killed, landed, cleared;

  invader_formation dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .Start(Start),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .origin_x(origin_x), .origin_y(origin_y), .alive_mask(alive_mask),
    .alive_count(alive_count), .dir_right(dir_right), .hit_ack(hit_ack),
    .hit_killed(hit_killed), .landed(landed), .cleared(cleared));

  always #5 Clk = ~Clk;

  int nvec = 0, nerr = 0;
  int m_ox, m_oy, m_div, m_st;
  bit m_dir, m_ack, m_killed;
  bit alive [ROWS][COLS];

  function automatic int n_alive();
    int n = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) n += int'(alive[r][c]);
    return n;
  endfunction

  task automatic model_reinit();
    m_ox = 64; m_oy = 32; m_dir = 1; m_div = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) alive[r][c] = 1;
  endtask

  task automatic model_reset();
    model_reinit();
    m_st = S_IDLE; m_ack = 0; m_killed = 0;
  endtask

  // One clock of the formation, from the behavioural rules.
  task automatic model_step(bit tk, bit st, bit hv, int hr, int hc);
    int lc = COLS, rc = 0, rb = 0, cnt;
    bit mv = 0;
    cnt = n_alive();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r][c]) begin
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > rb) rb = r;
        end
    if (lc == COLS) lc = 0;
    m_ack = hv;
    m_killed = hv && hr < ROWS && hc < COLS && alive[hr][hc];
    if (m_killed) alive[hr][hc] = 0;
    if (tk && (m_st == S_MR || m_st == S_ML)) begin
      if (m_div >= cnt / 4) begin mv = 1; m_div = 0; end
      else m_div++;
    end
    case (m_st)
      S_IDLE: if (st) m_st = S_MR;
      S_MR: if (mv) begin
        if (m_ox + (rc + 1) * CELL_W - 1 + STEP_X > SCREEN_W - 1) m_st = S_DROP;
        else m_ox += STEP_X;
      end
      S_ML: if (mv) begin
        if (m_ox + lc * CELL_W < STEP_X || m_ox - STEP_X < 0) m_st = S_DROP;
        else m_ox -= STEP_X;
      end
      S_DROP: begin
        m_oy += STEP_Y;
        m_dir = !m_dir;
        if (m_oy + (rb + 1) * CELL_H >= LAND_Y) m_st = S_LAND;
        else m_st = m_dir ? S_MR : S_ML;
      end
      default: if (st) begin model_reinit(); m_st = S_MR; end
    endcase
    if (n_alive() == 0) m_st = S_CLR;
  endtask

  function automatic logic [85:0] exp_vec();
    logic [N-1:0] m;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m[r*COLS + c] = alive[r][c];
    return {10'(m_ox), 10'(m_oy), m, 6'(n_alive()), m_dir, m_ack, m_killed,
            m_st == S_LAND, m_st == S_CLR};
  endfunction

  function automatic logic [85:0] dut_vec();
    return {origin_x, origin_y, alive_mask, alive_count, dir_right, hit_ack,
            hit_killed, landed, cleared};
  endfunction

  task automatic check(string name, logic [85:0] got, logic [85:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic reached(string name, bit ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got timeout expected condition reached", name);
    end
  endtask

  task automatic cyc(bit tk, bit st, bit hv, int hr, int hc);
    frame_tick = tk; Start = st; hit_valid = hv;
    hit_row = 3'(hr); hit_col = 4'(hc);
    @(posedge Clk);
    model_step(tk, st, hv, hr, hc);
    @(negedge Clk);
    frame_tick = 0; Start = 0; hit_valid = 0;
    check("model", dut_vec(), exp_vec());
  endtask

  task automatic do_reset();
    Reset = 1;
    model_reset();
    @(negedge Clk);
    check("reset", dut_vec(), RST_VEC);
    Reset = 0;
  endtask

  typedef struct {
    bit hv; int hr; int hc; bit ack; bit killed; int count;
  } hit_rec_t;
  hit_rec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bit ok;
    tbl[0] = '{1, 2, 3, 1, 1, 54};
    tbl[1] = '{1, 2, 3, 1, 0, 54};
    tbl[2] = '{1, 1, 12, 1, 0, 54};
    tbl[3] = '{1, 5, 0, 1, 0, 54};
    tbl[4] = '{0, 0, 0, 0, 0, 54};
    tbl[5] = '{1, 0, 0, 1, 1, 53};
    tbl[6] = '{1, 4, 10, 1, 1, 52};
    tbl[7] = '{1, 7, 15, 1, 0, 52};

    // Speed divider: 55 alive -> period 13, first move on the 14th tick
    do_reset();
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 0);
    chk_int("no_move_13", origin_x, 64);
    cyc(1, 0, 0, 0, 0);
    chk_int("first_move_x", origin_x, 66);
    chk_int("first_move_dir", dir_right, 1);

    // Right edge with full mask: 286 -> 288, then the next move drops
    for (int k = 0; k < 3000 && m_ox != 286; k++) cyc(1, 0, 0, 0, 0);
    chk_int("reach_286", origin_x, 286);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0);
    chk_int("edge_288", origin_x, 288);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0);
    chk_int("drop_hold_x", origin_x, 288);
    cyc(0, 0, 0, 0, 0);
    chk_int("drop_y", origin_y, 40);
    chk_int("drop_dir", dir_right, 0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0);
    chk_int("march_left_x", origin_x, 286);

    // Columns 9,10 dead: the right edge uses Rc=8, so the turn happens at 352
    do_reset();
    for (int r = 0; r < ROWS; r++) for (int c = 9; c < 11; c++) cyc(0, 0, 1, r, c);
    chk_int("count_45", alive_count, 45);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 5000 && m_st != S_DROP; k++) cyc(1, 0, 0, 0, 0);
    chk_int("drop_rc8_x", origin_x, 352);
    cyc(0, 0, 0, 0, 0);
    chk_int("drop_rc8_y", origin_y, 40);

    // Hit table in IDLE
    do_reset();
    foreach (tbl[i]) begin
      cyc(0, 0, tbl[i].hv, tbl[i].hr, tbl[i].hc);
      chk_int("tbl_hit", {hit_ack, hit_killed, alive_count},
              {tbl[i].ack, tbl[i].killed, 6'(tbl[i].count)});
    end
    chk_int("mask_bit25", alive_mask[25], 0);

    // Landing: one cell at (4,0) left, marches until bottom reaches 400
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == 4 && c == 0)) cyc(0, 0, 1, r, c);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 20000 && m_st != S_LAND; k++) cyc(1, 0, 0, 0, 0);
    chk_int("landed", landed, 1);
    chk_int("land_y", origin_y, 280);
    saved = m_ox;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    chk_int("land_frozen_x", origin_x, saved);
    cyc(0, 1, 0, 0, 0);
    chk_int("restart", {origin_x, origin_y, alive_count, dir_right, landed},
            {10'd64, 10'd32, 6'd55, 1'b1, 1'b0});

    // Clear: last kill coincides with a move tick
    do_reset();
    cyc(0, 1, 0, 0, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == 0 && c == 0)) cyc(0, 0, 1, r, c);
    cyc(1, 0, 1, 0, 0);
    chk_int("cleared", {cleared, alive_count, origin_x}, {1'b1, 6'd0, 10'd66});
    cyc(0, 1, 0, 0, 0);
    chk_int("clear_restart", {cleared, alive_count}, {1'b0, 6'd55});
    for (int k = 0; k < 3000 && m_st != S_DROP; k++) cyc(1, 0, 1, 7, 0);
    ok = (m_st == S_DROP);
    reached("reach_drop", ok);
    #2 Reset = 1;
    #1 check("async_reset", dut_vec(), RST_VEC);
    model_reset();
    @(negedge Clk);
    Reset = 0;

    // Random traffic against the model
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
          int'($urandom_range(0, 5)), int'($urandom_range(0, 11)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
